// File: rtl/alu_pipe.sv
// alu_pipe: Hack-style ALU with valid/ready handshake and optional shift-add multiply.
// Define ALU_PIPE_MUL_EN to build the multiply mode (IDLE/MUL FSM); otherwise mul is ignored.
module alu_pipe #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         zx,
    input  logic         nx,
    input  logic         zy,
    input  logic         ny,
    input  logic         f,
    input  logic         no,
    input  logic         mul,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         zr,
    output logic         ng,
    output logic         cy,
    output logic         busy
);
    logic [N-1:0] x_d, y_d, r_d, alu_d;
    logic [N:0]   sum_d;
    logic [N-1:0] out_q;
    logic         zr_q, ng_q, cy_q, vld_q;
    logic         accept, mul_sel;

    assign x_d   = nx ? ~(zx ? '0 : a) : (zx ? '0 : a);
    assign y_d   = ny ? ~(zy ? '0 : b) : (zy ? '0 : b);
    assign sum_d = {1'b0, x_d} + {1'b0, y_d};
    assign r_d   = f ? sum_d[N-1:0] : (x_d & y_d);
    assign alu_d = no ? ~r_d : r_d;

    assign in_ready  = !busy && (!vld_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out       = out_q;
    assign zr        = zr_q;
    assign ng        = ng_q;
    assign cy        = cy_q;
    assign out_valid = vld_q;

`ifdef ALU_PIPE_MUL_EN
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    typedef enum logic {IDLE, MUL} state_t;
    state_t        state_q;
    logic [N-1:0]  acc_q, mcand_q, mplier_q, acc_d;
    logic [CW-1:0] cnt_q;

    assign mul_sel = mul;
    assign busy    = state_q == MUL;
    assign acc_d   = mplier_q[0] ? acc_q + mcand_q : acc_q;
`else
    logic unused_mul;

    assign unused_mul = mul;
    assign mul_sel    = 1'b0;
    assign busy       = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
            zr_q  <= 1'b0;
            ng_q  <= 1'b0;
            cy_q  <= 1'b0;
            vld_q <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            if (vld_q && out_ready)
                vld_q <= 1'b0;
            if (accept && !mul_sel) begin
                out_q <= alu_d;
                zr_q  <= alu_d == '0;
                ng_q  <= alu_d[N-1];
                cy_q  <= f & sum_d[N];
                vld_q <= 1'b1;
            end
`ifdef ALU_PIPE_MUL_EN
            if (state_q == IDLE) begin
                if (accept && mul_sel) begin
                    state_q  <= MUL;
                    acc_q    <= '0;
                    mcand_q  <= a;
                    mplier_q <= b;
                    cnt_q    <= '0;
                end
            end else begin
                // one multiplier bit per edge; result lands on the Nth iteration edge
                acc_q    <= acc_d;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_q <= IDLE;
                    out_q   <= acc_d;
                    zr_q    <= acc_d == '0;
                    ng_q    <= acc_d[N-1];
                    cy_q    <= 1'b0;
                    vld_q   <= 1'b1;
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe (N=16), both macro builds.
module tb_alu_pipe;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [15:0] a = '0, b = '0;
    logic        zx = 0, nx = 0, zy = 0, ny = 0, f = 0, no = 0, mul = 0;
    logic        out_valid, out_ready = 1'b1;
    logic [15:0] out;
    logic        zr, ng, cy, busy;
    int          checks = 0;
    int          errors = 0;

    localparam logic [6:0] C_F = 7'b0000010, C_NO = 7'b0000001, C_ZX = 7'b0100000,
                           C_NX = 7'b0010000, C_ZY = 7'b0001000, C_MUL = 7'b1000000;

    alu_pipe #(.N(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .mul(mul),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .zr(zr), .ng(ng), .cy(cy), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] aa, input logic [15:0] bb, input logic [6:0] c);
        in_valid = v;
        a = aa;
        b = bb;
        {mul, zx, nx, zy, ny, f, no} = c;
    endtask

    task automatic expect_res(input string name, input logic [15:0] eo, input logic ezr,
                              input logic eng, input logic ecy);
        checks++;
        if ({out_valid, out, zr, ng, cy} !== {1'b1, eo, ezr, eng, ecy}) begin
            errors++;
            $display("FAIL %s: got vld=%b out=%h zr=%b ng=%b cy=%b, expected vld=1 out=%h zr=%b ng=%b cy=%b",
                     name, out_valid, out, zr, ng, cy, eo, ezr, eng, ecy);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out, zr, ng, cy, out_valid, busy} !== 21'h0) begin
            errors++;
            $display("FAIL reset_state: got out=%h zr=%b ng=%b cy=%b vld=%b busy=%b, expected all 0",
                     out, zr, ng, cy, out_valid, busy);
        end
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_alu_ops();
        out_ready = 1'b1;
        drive(1, 16'h7095, 16'h2795, C_F);
        step();
        expect_res("add", 16'h982A, 0, 1, 0);
        drive(1, 16'h7095, 16'h2795, 7'b0);
        step();
        expect_res("and", 16'h2095, 0, 0, 0);
        drive(1, 16'h7095, 16'h2795, C_ZX | C_NX | C_ZY | C_F);
        step();
        expect_res("const_minus1", 16'hFFFF, 0, 1, 0);
        drive(1, 16'h7095, 16'h2795, C_ZX | C_ZY | C_F);
        step();
        expect_res("const_zero", 16'h0000, 1, 0, 0);
        drive(1, 16'hFFFF, 16'h0001, C_F);
        step();
        expect_res("carry_wrap", 16'h0000, 1, 0, 1);
        drive(1, 16'h0001, 16'h0001, C_F | C_NO);
        step();
        expect_res("add_negate", 16'hFFFD, 0, 1, 0);
        drive(0, 16'h0, 16'h0, 7'b0);
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL consume_clears: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1, 16'h0001, 16'h0002, C_F);
        step();
        expect_res("bp_first", 16'h0003, 0, 0, 0);
        drive(1, 16'h0005, 16'h0006, C_F);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out !== 16'h0003 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d: got in_ready=%b out=%h vld=%b expected 0/0003/1",
                         i, in_ready, out, out_valid);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b expected 1", in_ready);
        end
        step();
        expect_res("bp_second", 16'h000B, 0, 0, 0);
        drive(0, 16'h0, 16'h0, 7'b0);
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        drive(1, 16'h1234, 16'h1111, C_F);
        out_ready = 1'b0;
        step();
        drive(0, 16'h0, 16'h0, 7'b0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({out, out_valid, busy, zr, ng, cy} !== 21'h0) begin
            errors++;
            $display("FAIL async_reset: got out=%h vld=%b busy=%b zr=%b ng=%b cy=%b expected all 0",
                     out, out_valid, busy, zr, ng, cy);
        end
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        #1;
    endtask

`ifdef ALU_PIPE_MUL_EN
    task automatic run_mul(input string name, input logic [15:0] aa, input logic [15:0] bb,
                           input logic [15:0] eo, input logic ezr, input logic eng);
        drive(1, aa, bb, C_MUL);
        step();
        drive(0, 16'h0, 16'h0, 7'b0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy%0d: got busy=%b in_ready=%b vld=%b expected 1/0/0",
                         name, i, busy, in_ready, out_valid);
            end
            step();
        end
        expect_res(name, eo, ezr, eng, 0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_busy: got %b expected 0", name, busy);
        end
        step();
    endtask

    task automatic test_multiply();
        out_ready = 1'b1;
        run_mul("mul_3x5", 16'h0003, 16'h0005, 16'h000F, 0, 0);
        run_mul("mul_wrap", 16'h0100, 16'h0100, 16'h0000, 1, 0);
        run_mul("mul_1234x7", 16'h1234, 16'h0007, 16'h7F6C, 0, 0);
        run_mul("mul_neg", 16'hFFFF, 16'h0003, 16'hFFFD, 0, 1);
    endtask

    task automatic test_reset_mid_mul();
        drive(1, 16'h0003, 16'h0005, C_MUL);
        step();
        drive(0, 16'h0, 16'h0, 7'b0);
        repeat (5) step();
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_abort: got vld=%b busy=%b expected 0/0", out_valid, busy);
        end
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_abort_ready: got %b expected 1", in_ready);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mul_stale%0d: got vld=%b busy=%b expected 0/0", i, out_valid, busy);
            end
        end
    endtask
`else
    task automatic test_mul_disabled();
        out_ready = 1'b1;
        drive(1, 16'h0003, 16'h0005, C_MUL | C_F);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL nomul_busy_pre: got %b expected 0", busy);
        end
        step();
        drive(0, 16'h0, 16'h0, 7'b0);
        expect_res("nomul_add", 16'h0008, 0, 0, 0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL nomul_busy: got %b expected 0", busy);
        end
        step();
    endtask
`endif

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'(16'h1000 * i), 16'h0101, C_F);
            step();
            expect_res("b2b", 16'(16'h1000 * i + 16'h0101), 0, 0, 0);
        end
        drive(0, 16'h0, 16'h0, 7'b0);
        step();
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
`ifdef ALU_PIPE_MUL_EN
        test_multiply();
        test_reset_mid_mul();
`else
        test_mul_disabled();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
